// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. It owns the PC and the IF/ID register,
//               and handles stall, redirect/flush, PC wrap and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP         = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instruction,
  output logic [15:0] pc,
  output logic [15:0] if_id_instruction,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_next,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_if_pc;
  logic [15:0] r_if_pc_next;
  logic        r_valid;
  logic [15:0] r_count;

  logic [15:0] w_pc_next;
  logic [15:0] w_instr_next;
  logic [15:0] w_if_pc_next;
  logic [15:0] w_if_pc_next_next;
  logic        w_valid_next;
  logic [15:0] w_count_next;
  logic [15:0] w_pc_inc;

  assign w_pc_inc = r_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority: redirect > stall (RUN only) > halted hold > normal fetch
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_instr_next      = r_instr;
    w_if_pc_next      = r_if_pc;
    w_if_pc_next_next = r_if_pc_next;
    w_valid_next      = r_valid;
    w_count_next      = r_count;
    if (branch_taken) begin
      w_pc_next    = branch_target;
      w_instr_next = NOP;
      w_valid_next = 1'b0;
      w_state_next = ST_RUN;
    end else if (stall && (r_state == ST_RUN)) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_HALTED) begin
      w_instr_next = NOP;
      w_valid_next = 1'b0;
    end else begin
      w_instr_next      = instruction;
      w_if_pc_next      = r_pc;
      w_if_pc_next_next = w_pc_inc;
      w_valid_next      = 1'b1;
      w_count_next      = r_count + 16'd1;
      w_pc_next         = w_pc_inc;
      if (instruction[15:12] == HALT_OPCODE) begin
        w_state_next = ST_HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_if_pc      <= 16'h0000;
      r_if_pc_next <= 16'h0000;
      r_valid      <= 1'b0;
      r_count      <= 16'h0000;
    end else begin
      r_pc         <= w_pc_next;
      r_instr      <= w_instr_next;
      r_if_pc      <= w_if_pc_next;
      r_if_pc_next <= w_if_pc_next_next;
      r_valid      <= w_valid_next;
      r_count      <= w_count_next;
    end
  end

  assign pc                = r_pc;
  assign if_id_instruction = r_instr;
  assign if_id_pc          = r_if_pc;
  assign if_id_pc_next     = r_if_pc_next;
  assign if_id_valid       = r_valid;
  assign halted            = (r_state == ST_HALTED);
  assign fetch_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios plus
//               randomized traffic against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic [15:0] if_id_instruction;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_next;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] instruction_w;
  logic [15:0] pc_w;
  logic [15:0] if_id_instruction_w;
  logic [15:0] if_id_pc_w;
  logic [15:0] if_id_pc_next_w;
  logic        if_id_valid_w;
  logic        halted_w;
  logic [15:0] fetch_count_w;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_if_pc, m_if_pc_next, m_count;
  logic        m_valid, m_halted;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(instruction), .pc(pc),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(instruction_w), .pc(pc_w),
    .if_id_instruction(if_id_instruction_w), .if_id_pc(if_id_pc_w),
    .if_id_pc_next(if_id_pc_next_w), .if_id_valid(if_id_valid_w),
    .halted(halted_w), .fetch_count(fetch_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction   = mem[pc];
  assign instruction_w = mem[pc_w];

  task automatic fill_default_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 16'h1000 + a[15:0];
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_if_pc = 16'h0000;
    m_if_pc_next = 16'h0000; m_count = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [15:0] tgt);
    logic [15:0] word;
    if (br) begin
      m_pc = tgt; m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!st) begin
      word         = mem[m_pc];
      m_instr      = word;
      m_if_pc      = m_pc;
      m_if_pc_next = m_pc + 16'd2;
      m_valid      = 1'b1;
      m_count      = m_count + 16'd1;
      m_pc         = m_pc + 16'd2;
      if (word[15:12] == 4'hF) m_halted = 1'b1;
    end
  endtask

  task automatic cycle(input logic st, input logic br, input logic [15:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    #1;
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 16'h0000) $display("FAIL reset_pc got %h exp 0000", pc); else passed++;
    checks++; if (if_id_instruction !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", if_id_instruction); else passed++;
    checks++; if (if_id_pc !== 16'h0000 || if_id_pc_next !== 16'h0000) $display("FAIL reset_if_pc got %h/%h exp 0000/0000", if_id_pc, if_id_pc_next); else passed++;
    checks++; if (if_id_valid !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags got v=%b h=%b exp 0/0", if_id_valid, halted); else passed++;
    checks++; if (fetch_count !== 16'h0000) $display("FAIL reset_count got %h exp 0000", fetch_count); else passed++;
    checks++; if (pc_w !== 16'hFFFE) $display("FAIL reset_pc_wrap got %h exp fffe", pc_w); else passed++;
  endtask

  task automatic test_free_run();
    logic [15:0] exp_pc;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      exp_pc = 16'(2 * i);
      checks++;
      if (pc !== exp_pc || if_id_pc !== exp_pc - 16'd2 || if_id_valid !== 1'b1 ||
          if_id_instruction !== 16'h1000 + exp_pc - 16'd2)
        $display("FAIL free_run_%0d got pc=%h ifpc=%h v=%b ins=%h exp pc=%h ifpc=%h v=1 ins=%h",
                 i, pc, if_id_pc, if_id_valid, if_id_instruction, exp_pc, exp_pc - 16'd2, 16'h1000 + exp_pc - 16'd2);
      else passed++;
    end
    checks++; if (fetch_count !== 16'd5) $display("FAIL free_run_count got %0d exp 5", fetch_count); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0000);
      checks++;
      if (pc !== 16'h0006 || if_id_pc !== 16'h0004 || if_id_instruction !== 16'h1004 || fetch_count !== 16'd3)
        $display("FAIL stall_hold_%0d got pc=%h ifpc=%h ins=%h cnt=%0d exp 0006/0004/1004/3",
                 i, pc, if_id_pc, if_id_instruction, fetch_count);
      else passed++;
    end
    cycle(1'b0, 1'b0, 16'h0000);
    checks++; if (pc !== 16'h0008 || if_id_pc !== 16'h0006) $display("FAIL stall_release got pc=%h ifpc=%h exp 0008/0006", pc, if_id_pc); else passed++;
  endtask

  task automatic test_branch_under_stall();
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 16'h0040);
    checks++;
    if (pc !== 16'h0040 || if_id_valid !== 1'b0 || if_id_instruction !== 16'h0000 ||
        if_id_pc !== 16'h0008 || if_id_pc_next !== 16'h000A || fetch_count !== 16'd5)
      $display("FAIL branch_flush got pc=%h v=%b ins=%h ifpc=%h nxt=%h cnt=%0d exp 0040/0/0000/0008/000a/5",
               pc, if_id_valid, if_id_instruction, if_id_pc, if_id_pc_next, fetch_count);
    else passed++;
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (if_id_instruction !== 16'h1040 || if_id_pc !== 16'h0040 || if_id_valid !== 1'b1 || pc !== 16'h0042)
      $display("FAIL branch_target_fetch got ins=%h ifpc=%h v=%b pc=%h exp 1040/0040/1/0042",
               if_id_instruction, if_id_pc, if_id_valid, pc);
    else passed++;
  endtask

  task automatic test_halt();
    mem[12] = 16'hF000;
    do_reset();
    repeat (7) cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (if_id_instruction !== 16'hF000 || if_id_valid !== 1'b1 || halted !== 1'b1 || pc !== 16'h000E || fetch_count !== 16'd7)
      $display("FAIL halt_issue got ins=%h v=%b h=%b pc=%h cnt=%0d exp f000/1/1/000e/7",
               if_id_instruction, if_id_valid, halted, pc, fetch_count);
    else passed++;
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== 16'h000E || if_id_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 16'd7)
      $display("FAIL halt_hold got pc=%h v=%b h=%b cnt=%0d exp 000e/0/1/7", pc, if_id_valid, halted, fetch_count);
    else passed++;
    cycle(1'b0, 1'b1, 16'h0000);
    checks++; if (halted !== 1'b0 || pc !== 16'h0000) $display("FAIL halt_branch got h=%b pc=%h exp 0/0000", halted, pc); else passed++;
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (if_id_instruction !== 16'h1000 || if_id_valid !== 1'b1 || fetch_count !== 16'd8)
      $display("FAIL halt_resume got ins=%h v=%b cnt=%0d exp 1000/1/8", if_id_instruction, if_id_valid, fetch_count);
    else passed++;
    mem[12] = 16'h100C;
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc_w !== 16'h0000 || if_id_pc_next_w !== 16'h0000 || if_id_pc_w !== 16'hFFFE || if_id_instruction_w !== 16'h0FFE)
      $display("FAIL pc_wrap got pc=%h nxt=%h ifpc=%h ins=%h exp 0000/0000/fffe/0ffe",
               pc_w, if_id_pc_next_w, if_id_pc_w, if_id_instruction_w);
    else passed++;
  endtask

  task automatic test_reset_mid();
    mem[4] = 16'hF123;
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 16'h0000);
    checks++; if (halted !== 1'b1) $display("FAIL mid_reset_setup got h=%b exp 1", halted); else passed++;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    checks++;
    if (pc !== 16'h0000 || if_id_instruction !== 16'h0000 || if_id_pc !== 16'h0000 || if_id_pc_next !== 16'h0000 ||
        if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'h0000)
      $display("FAIL mid_reset got pc=%h ins=%h ifpc=%h nxt=%h v=%b h=%b cnt=%h exp all zero",
               pc, if_id_instruction, if_id_pc, if_id_pc_next, if_id_valid, halted, fetch_count);
    else passed++;
    mem[4] = 16'h1004;
  endtask

  task automatic test_random();
    logic        st, br;
    logic [15:0] tgt;
    int          errs;
    errs = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = 16'($urandom) & 16'hFFFE;
      model_step(st, br, tgt);
      cycle(st, br, tgt);
      checks++;
      if (pc !== m_pc || if_id_pc !== m_if_pc || if_id_pc_next !== m_if_pc_next || if_id_valid !== m_valid ||
          halted !== m_halted || fetch_count !== m_count || (!m_halted && if_id_instruction !== m_instr)) begin
        if (errs < 10)
          $display("FAIL random_%0d got pc=%h ifpc=%h nxt=%h v=%b h=%b cnt=%h ins=%h exp %h/%h/%h/%b/%b/%h/%h",
                   i, pc, if_id_pc, if_id_pc_next, if_id_valid, halted, fetch_count, if_id_instruction,
                   m_pc, m_if_pc, m_if_pc_next, m_valid, m_halted, m_count, m_instr);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    fill_default_mem();
    #1;
    test_reset();
    test_free_run();
    test_stall();
    test_branch_under_stall();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
